// File: rtl/sub_unit_pkg.sv
// Shared definitions for the chunked serial subtractor: FSM state encoding
// and the fixed number of bits handled per cycle.
// Latency: n/a (definitions only). Backpressure: n/a.
package sub_unit_pkg;

   // Bits processed per RUN cycle; fixed, not a user parameter.
   localparam int CHUNK = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub_chunk.sv
// Purpose: combinational 2-bit subtract with borrow, d = x - y - bin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: x, y - 2-bit operand slices; bin - borrow-in;
//        d - 2-bit difference; bout - borrow-out (result went negative).
module sub_chunk (
   input  logic [1:0] x,
   input  logic [1:0] y,
   input  logic       bin,
   output logic [1:0] d,
   output logic       bout
);

   logic [2:0] diff;

   // A 3-bit two's-complement result covers -4..3, so bit 2 is the borrow.
   assign diff = {1'b0, x} - {1'b0, y} - {2'b00, bin};
   assign d    = diff[1:0];
   assign bout = diff[2];

endmodule

// File: rtl/sub_unit.sv
// Purpose: serial unsigned subtractor f = a - b (mod 2^WIDTH), 2 bits per cycle, with borrow.
// Latency: out_valid high WIDTH/2 edges after the accept edge; one transaction in flight.
// Backpressure: DONE holds f/borrow stable until out_ready; in_ready only in IDLE.
// Ports: m_clock, p_reset (async, active-low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/f/borrow result handshake.
// Config: define SUB_UNIT_SAT_EN to clamp f to 0 when the final borrow is set.
module sub_unit
   import sub_unit_pkg::*;
#(
   parameter int WIDTH = 8   // must be even and >= 2
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             borrow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t                 state;
   state_t                 state_nxt;
   logic [WIDTH-1:0]       a_r;
   logic [WIDTH-1:0]       b_r;
   logic [IDX_W-1:0]       idx;
   logic                   bchain;
   logic [CHUNK-1:0]       x_c;
   logic [CHUNK-1:0]       y_c;
   logic [CHUNK-1:0]       d_c;
   logic                   bout_c;
   logic                   last_chunk;

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

   // Operands come from the captured copies, so a/b may change freely in RUN.
   assign x_c = a_r[idx*CHUNK +: CHUNK];
   assign y_c = b_r[idx*CHUNK +: CHUNK];

   sub_chunk u_sub_chunk (
      .x    (x_c),
      .y    (y_c),
      .bin  (bchain),
      .d    (d_c),
      .bout (bout_c)
   );

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = RUN;
         RUN:     if (last_chunk) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         a_r    <= '0;
         b_r    <= '0;
         idx    <= '0;
         bchain <= 1'b0;
         f      <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r    <= a;
                  b_r    <= b;
                  idx    <= '0;
                  bchain <= 1'b0;
                  borrow <= 1'b0;
               end
            end
            RUN: begin
               f[idx*CHUNK +: CHUNK] <= d_c;
               bchain                <= bout_c;
               idx                   <= idx + 1'b1;
               if (last_chunk) begin
                  // Explicit wrap keeps idx in range when NCHUNK is not a power of 2.
                  idx    <= '0;
                  borrow <= bout_c;
`ifdef SUB_UNIT_SAT_EN
                  // Later assignment overrides the chunk write above.
                  if (bout_c) f <= '0;
`endif
               end
            end
            default: ;  // DONE: hold f and borrow for the consumer
         endcase
      end
   end

endmodule

// File: doc/sub_unit.md
SUB_UNIT -- requirements
Module: sub_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; SHALL be a multiple of 2, minimum 2.
REQ-002 Parameter CHUNK, fixed at 2: bits processed per cycle; not user-overridable.
REQ-003 m_clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 p_reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair a/b offered.
REQ-006 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 out_valid  output  1  result f and borrow valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 f  output  WIDTH  registered result a - b.
REQ-012 borrow  output  1  high when a < b, unsigned compare.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE->RUN when in_valid && in_ready at an edge: a and b captured, chunk index cleared, borrow chain cleared.
REQ-015 RUN: each cycle subtracts chunk i (bits 2i+1:2i) with the borrow-in from chunk i-1, writes the result chunk into f, and increments the index.
REQ-016 RUN->DONE on the edge that processes chunk WIDTH/2-1; out_valid SHALL be high after edge k+WIDTH/2 when operands were accepted at edge k.
REQ-017 DONE: f and borrow SHALL hold stable while out_valid && !out_ready (backpressure of any length).
REQ-018 DONE->IDLE on out_valid && out_ready; in_ready rises the following cycle; no overlap of input and output transactions.
REQ-019 Arithmetic: modulo 2^WIDTH; borrow = final chunk borrow-out; a == b -> f = 0, borrow = 0.
REQ-020 Changes on a/b/in_valid outside the IDLE accept edge SHALL NOT affect the result in flight.
REQ-021 f SHALL NOT be considered valid while out_valid is low; its contents are don't-care in RUN.

Reset
REQ-022 p_reset low SHALL immediately force IDLE, f = 0, borrow = 0, out_valid = 0, in_ready = 1 after release, chunk index = 0.
REQ-023 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no result is produced after release.

Configuration
REQ-024 Macro SUB_UNIT_SAT_EN defined: on final borrow = 1, f SHALL be forced to 0 when DONE is entered; borrow still reports 1.
REQ-025 SUB_UNIT_SAT_EN undefined: f SHALL be the wrapped modulo result; borrow as REQ-019.

Structure
REQ-026 Package sub_unit_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the CHUNK constant.
REQ-027 One sub-module sub_chunk: combinational 2-bit subtract, inputs x[1:0], y[1:0], bin; outputs d[1:0], bout; instantiated once in sub_unit.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x23 accepted at edge k -> out_valid high after edge k+4, f=0x37, borrow=0.
REQ-029 a=0x10, b=0x20 -> borrow=1; f=0xF0 without SUB_UNIT_SAT_EN, f=0x00 with it.
REQ-030 Hold out_ready=0 for 10 cycles in DONE -> out_valid, f and borrow unchanged; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-031 Assert p_reset at RUN chunk index 2 -> outputs read 0 immediately, in_ready=1 after release, no out_valid pulse.
REQ-032 Operand sweep: back-to-back transactions with a/b toggled during RUN; equal operands (0xFF-0xFF) -> f=0, borrow=0; 0x00-0x01 -> f=0xFF, borrow=1 (wrap).
